sysref_gate_ctrl: RTL and testbench
===================================

# sysref_gate_ctrl

Sequences delivery of the board SYSREF to the RF-ADC/RF-DAC tiles for multi-tile synchronisation. Takes the SYSREF sample already registered on `pl_clk` by the PL capture flop and measures its period until it is stable. It then forwards a programmed number of whole SYSREF pulses to the converters and closes the gate. This keeps the converter SYSREF input quiet except during a controlled sync window, and flags loss of lock or missing SYSREF.

## Interface
- `CNT_W`, 16: width of period counter and period ports.
- `LOCK_PERIODS`, 4: consecutive matching periods required before the gate opens (1..15).
- `TIMEOUT`, 65535: cycles without a SYSREF rising edge before error (≤ 2^CNT_W−1).
- `pl_clk` in 1: AXI4-Stream-rate PL clock, the same clock as the capture flop.
- `rst` in 1: synchronous, active-high reset.
- `sysref_in` in 1: registered SYSREF sample, `pl_clk` domain.
- `arm` in 1: single-cycle start pulse; ignored unless IDLE, DONE or ERROR.
- `abort` in 1: return to IDLE next cycle from any state; wins over `arm`.
- `period_exp` in CNT_W: expected SYSREF period in `pl_clk` cycles; sampled on accepted `arm`.
- `pass_edges` in 8: number of pulses to forward; sampled on accepted `arm`; 0 = forward until `abort`.
- `sysref_out` out 1: gated SYSREF to the converters.
- `busy` out 1: state is MEASURE or GATED.
- `locked` out 1: state is GATED.
- `done` out 1: state is DONE.
- `err` out 1: state is ERROR.
- `err_code` out 2: 0 none, 1 timeout, 2 period mismatch after lock, 3 reserved.
- `period_meas` out CNT_W: last measured period.

## Operation
- Edge detect: `rise = sysref_in & ~sysref_q`, where `sysref_q` is `sysref_in` delayed by one cycle.
- Period counter `cnt`:
  - Set to 1 on `rise`; otherwise increments, saturating at all-ones.
  - Cleared on accepted `arm`.
  - Not compared before the first `rise` after `arm`.
- States: IDLE, MEASURE, GATED, DONE, ERROR.
- IDLE:
  - `arm` → MEASURE.
  - Captures `period_exp` and `pass_edges`.
  - Clears `good`, `edges`, `err_code` and the first-edge flag.
- MEASURE:
  - On each `rise` after the first: `period_meas <= cnt`.
  - If `cnt == period_exp`, `good++`; else `good <= 0`.
  - When `good` reaches `LOCK_PERIODS` → GATED on that same `rise`.
  - `cnt == TIMEOUT` with no `rise` → ERROR, code 1.
- GATED:
  - `fwd` sets on the first `rise` inside GATED, so the pulse that achieved lock is never forwarded partially.
  - While `fwd` is set, `sysref_out <= sysref_in`.
  - Each forwarded `rise` increments `edges`.
  - Period check continues on every `rise`. A mismatch → ERROR, code 2; `sysref_out` is 0 from the next cycle.
  - `cnt == TIMEOUT` → ERROR, code 1.
  - After `edges == pass_edges` (nonzero), forwarding continues until the first cycle `sysref_in == 0`, then → DONE. Only whole pulses are emitted.
- DONE and ERROR: hold, `sysref_out = 0`. `arm` re-arms (→ MEASURE); `abort` → IDLE.
- `err_code` holds until the next accepted `arm`, `abort` or `rst`.
- Simultaneous events:
  - `abort` with anything → IDLE.
  - Mismatch `rise` and last-edge completion in the same cycle → ERROR.
  - Timeout and `rise` in the same cycle → `rise` wins.
- `period_exp < 2` is illegal: mismatch is guaranteed and the block never locks.

## Timing
- Reset values: state IDLE; `sysref_out`, `busy`, `locked`, `done`, `err` all 0; `err_code` 0; `period_meas` 0; all counters 0.
- `sysref_out` is registered: 1 cycle of latency from `sysref_in`; pulse width is preserved exactly.
- Status outputs are decoded from registered state, so they change the cycle after the causing event.
- Lock takes `LOCK_PERIODS + 1` rising edges after `arm`. The first forwarded `rise` is edge `LOCK_PERIODS + 2`.
- `rst` mid-pulse: `sysref_out` is 0 the cycle after `rst`, with no glitch.
- `abort` mid-pulse truncates the pulse the same way. This is acceptable because `abort` is a software recovery path.

## Structure
- Package `sysref_ctrl_pkg`:
  - `sysref_state_e` enum.
  - `err_code_e` enum (NONE, TIMEOUT, MISMATCH).
  - Default `CNT_W`.
- One sub-module, `sysref_period_meter`, owns the edge detect, saturating counter and `period_meas`. It outputs `rise`, `cnt_match` and `timeout`.
- The FSM, `good`/`edges` counters and the output gate stay in `sysref_gate_ctrl`.

## Test plan
- Period 16, pulse width 2, `period_exp = 16`, `pass_edges = 3`:
  - `locked` asserts after edge 5.
  - Exactly 3 two-cycle pulses on `sysref_out`, each 1 cycle after input.
  - Then `done = 1`.
- Same setup, 6th period stretched to 17 after lock → `err = 1`, `err_code = 2`, `sysref_out` stays 0.
- No SYSREF after `arm`, `TIMEOUT = 100` → ERROR with code 1 exactly 100 cycles after the last `rise`.
- `pass_edges = 0`:
  - Pulses keep forwarding indefinitely.
  - `abort` → IDLE next cycle, `sysref_out = 0`.
- Periods 16, 16, 15, 16, 16, 16, 16 → `good` resets at the 15. Lock occurs on the fourth consecutive 16, and `period_meas` reads 16.
- `rst` asserted while `sysref_out = 1` → all outputs at reset values the next cycle; a fresh `arm` locks normally.

Source files
------------

// File: rtl/sysref_ctrl_pkg.sv
// Shared types for the SYSREF gating controller: FSM states, error codes and
// the default period-counter width.
package sysref_ctrl_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_GATED,
    ST_DONE,
    ST_ERROR
  } sysref_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_MISMATCH = 2'd2
  } err_code_e;

endpackage

// File: rtl/sysref_period_meter.sv
// SYSREF rising-edge detector and saturating period counter. Reports whether the
// current count matches the expected period and holds the last measured period.
module sysref_period_meter
  import sysref_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 65535
) (
  input  logic             pl_clk,
  input  logic             rst,
  input  logic             sysref_in,
  input  logic             clr,
  input  logic             meas_armed,
  input  logic [CNT_W-1:0] period_exp,
  output logic             rise,
  output logic             cnt_match,
  output logic             timeout,
  output logic [CNT_W-1:0] period_meas
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  logic             sysref_q;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of cycles since the previous rise at the cycle of a rise
  assign rise      = sysref_in & ~sysref_q;
  assign cnt_match = (cnt == period_exp);
  assign timeout   = (cnt == TO_VAL) & ~rise;

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      sysref_q    <= 1'b0;
      cnt         <= '0;
      period_meas <= '0;
    end else begin
      sysref_q <= sysref_in;
      if (clr) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (rise && meas_armed) begin
        period_meas <= cnt;
      end
    end
  end

endmodule

// File: rtl/sysref_gate_ctrl.sv
// SYSREF gate sequencer: waits for a stable SYSREF period, forwards a programmed
// number of whole pulses to the converter tiles, then closes the gate.
module sysref_gate_ctrl
  import sysref_ctrl_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LOCK_PERIODS = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic             pl_clk,
  input  logic             rst,
  input  logic             sysref_in,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] period_exp,
  input  logic [7:0]       pass_edges,
  output logic             sysref_out,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] period_meas
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_PERIODS);

  sysref_state_e    state_q, state_n;
  err_code_e        err_q, err_n;
  logic [CNT_W-1:0] per_exp_q;
  logic [7:0]       pass_q;
  logic [7:0]       edges_q;
  logic [3:0]       good_q;
  logic             first_q;
  logic             fwd_q;
  logic             out_q;

  logic rise, cnt_match, timeout;
  logic in_meas, in_gated, accept_arm;
  logic mismatch, lock_hit, fwd_now, last_done;

  assign in_meas    = (state_q == ST_MEASURE);
  assign in_gated   = (state_q == ST_GATED);
  assign accept_arm = arm & ~abort & (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

  sysref_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .pl_clk      (pl_clk),
    .rst         (rst),
    .sysref_in   (sysref_in),
    .clr         (accept_arm),
    .meas_armed  (first_q & (in_meas | in_gated)),
    .period_exp  (per_exp_q),
    .rise        (rise),
    .cnt_match   (cnt_match),
    .timeout     (timeout),
    .period_meas (period_meas)
  );

  assign mismatch  = in_gated & rise & ~cnt_match;
  assign lock_hit  = in_meas & rise & first_q & cnt_match & ((good_q + 4'd1) == LOCK_N);
  // The rise that opens forwarding is itself forwarded, so pulse width is kept
  assign fwd_now   = in_gated & (fwd_q | rise);
  assign last_done = in_gated & (pass_q != 8'd0) & (edges_q == pass_q) & ~sysref_in;

  always_comb begin
    state_n = state_q;
    err_n   = err_q;
    if (abort) begin
      state_n = ST_IDLE;
      err_n   = ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (arm) begin
            state_n = ST_MEASURE;
            err_n   = ERR_NONE;
          end
        end
        ST_MEASURE: begin
          if (lock_hit) begin
            state_n = ST_GATED;
          end else if (timeout) begin
            state_n = ST_ERROR;
            err_n   = ERR_TIMEOUT;
          end
        end
        ST_GATED: begin
          if (mismatch) begin
            state_n = ST_ERROR;
            err_n   = ERR_MISMATCH;
          end else if (timeout) begin
            state_n = ST_ERROR;
            err_n   = ERR_TIMEOUT;
          end else if (last_done) begin
            state_n = ST_DONE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      err_q     <= ERR_NONE;
      per_exp_q <= '0;
      pass_q    <= '0;
      edges_q   <= '0;
      good_q    <= '0;
      first_q   <= 1'b0;
      fwd_q     <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      err_q   <= err_n;
      out_q   <= fwd_now & sysref_in & ~mismatch & ~abort;
      if (abort) begin
        good_q  <= '0;
        edges_q <= '0;
        first_q <= 1'b0;
        fwd_q   <= 1'b0;
      end else if (accept_arm) begin
        per_exp_q <= period_exp;
        pass_q    <= pass_edges;
        good_q    <= '0;
        edges_q   <= '0;
        first_q   <= 1'b0;
        fwd_q     <= 1'b0;
      end else begin
        if (in_meas && rise) begin
          first_q <= 1'b1;
          if (first_q) begin
            good_q <= cnt_match ? good_q + 4'd1 : 4'd0;
          end
        end
        if (in_gated && rise && cnt_match) begin
          fwd_q   <= 1'b1;
          edges_q <= edges_q + 8'd1;
        end
        if (state_n != ST_GATED) begin
          fwd_q <= 1'b0;
        end
      end
    end
  end

  assign sysref_out = out_q;
  assign busy       = in_meas | in_gated;
  assign locked     = in_gated;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERROR);
  assign err_code   = err_q;

endmodule

// File: tb/tb_sysref_gate_ctrl.sv
// Bench for sysref_gate_ctrl: pulse trains are described as start/width lists and
// the expected gate behaviour is derived from them with plain arithmetic.
module tb_sysref_gate_ctrl;

  localparam int CNT_W  = 16;
  localparam int LOCKP  = 4;
  localparam int TMO    = 100;
  localparam int MAXLEN = 1500;

  logic             pl_clk = 1'b0;
  logic             rst, sysref_in, arm, abort;
  logic [CNT_W-1:0] period_exp;
  logic [7:0]       pass_edges;
  logic             sysref_out, busy, locked, done, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] period_meas;

  sysref_gate_ctrl #(
    .CNT_W        (CNT_W),
    .LOCK_PERIODS (LOCKP),
    .TIMEOUT      (TMO)
  ) dut (
    .pl_clk      (pl_clk),
    .rst         (rst),
    .sysref_in   (sysref_in),
    .arm         (arm),
    .abort       (abort),
    .period_exp  (period_exp),
    .pass_edges  (pass_edges),
    .sysref_out  (sysref_out),
    .busy        (busy),
    .locked      (locked),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .period_meas (period_meas)
  );

  always #5 pl_clk = ~pl_clk;

  int errors = 0;
  int checks = 0;

  // Pulse train: start cycle (relative to the arm cycle) and width of each pulse
  int         s_q[$];
  int         w_q[$];
  bit         wave[MAXLEN];
  bit         outm[MAXLEN];
  logic [4:0] ev[MAXLEN];   // {sysref_out, busy, locked, done, err}
  int         exp_len;
  logic [1:0] exp_code;
  int         exp_pm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void push_pulse(input int gap, input int w);
    if (s_q.size() == 0) s_q.push_back(gap);
    else s_q.push_back(s_q[$] + gap);
    w_q.push_back(w);
  endfunction

  function automatic void clear_train();
    s_q.delete();
    w_q.delete();
  endfunction

  // Expected behaviour: lock on the LOCKP-th consecutive matching period, then
  // forward whole pulses while periods match; end on pass count, mismatch or silence.
  function automatic void build_model(input int expp, input int pass, input int tail);
    int lock_k, run, t_end, kind, last_r, fwd;
    for (int c = 0; c < MAXLEN; c++) begin
      wave[c] = 1'b0;
      outm[c] = 1'b0;
    end
    foreach (s_q[k])
      for (int d = 0; d < w_q[k]; d++)
        if (s_q[k] + d < MAXLEN) wave[s_q[k] + d] = 1'b1;
    lock_k = -1;
    run    = 0;
    for (int k = 1; k < s_q.size(); k++) begin
      if (s_q[k] - s_q[k-1] == expp) run++;
      else run = 0;
      if (run == LOCKP) begin
        lock_k = k;
        break;
      end
    end
    kind     = 0;   // 0 none yet, 1 done, 2 error
    exp_code = 2'd0;
    t_end    = 0;
    last_r   = s_q.size() - 1;
    fwd      = 0;
    if (lock_k >= 0) begin
      for (int j = lock_k + 1; j < s_q.size(); j++) begin
        if (s_q[j] - s_q[j-1] != expp) begin
          t_end = s_q[j]; kind = 2; exp_code = 2'd2; last_r = j;
          break;
        end
        for (int d = 0; d < w_q[j]; d++) outm[s_q[j] + d] = 1'b1;
        fwd++;
        if (pass != 0 && fwd == pass) begin
          t_end = s_q[j] + w_q[j]; kind = 1; last_r = j;
          break;
        end
      end
    end
    if (kind == 0) begin
      t_end = s_q[$] + TMO; kind = 2; exp_code = 2'd1;
    end
    exp_pm  = s_q[last_r] - s_q[last_r-1];
    exp_len = t_end + tail;
    for (int c = 0; c < exp_len; c++) begin
      ev[c][4] = outm[c] && (c < t_end);
      ev[c][3] = (c < t_end);
      ev[c][2] = (lock_k >= 0) && (c >= s_q[lock_k]) && (c < t_end);
      ev[c][1] = (kind == 1) && (c >= t_end);
      ev[c][0] = (kind == 2) && (c >= t_end);
    end
  endfunction

  // Cycle 0 carries the arm pulse; outputs are sampled on the falling edge
  task automatic play(input int len, input string tag);
    for (int c = 0; c < len; c++) begin
      arm       = (c == 0);
      sysref_in = wave[c];
      @(posedge pl_clk);
      @(negedge pl_clk);
      chk($sformatf("%s_c%0d", tag, c), 32'({sysref_out, busy, locked, done, err}), 32'(ev[c]));
    end
    arm = 1'b0;
  endtask

  task automatic tick();
    @(posedge pl_clk);
    @(negedge pl_clk);
  endtask

  initial begin
    int expp, pass, wmax, per, cut;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; sysref_in = 1'b0;
    period_exp = '0; pass_edges = '0;
    repeat (3) @(posedge pl_clk);
    @(negedge pl_clk);
    chk("reset_flags", 32'({sysref_out, busy, locked, done, err}), 32'd0);
    chk("reset_code", 32'(err_code), 32'd0);
    chk("reset_pmeas", 32'(period_meas), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal: period 16, width 2, three pulses forwarded
    clear_train();
    push_pulse(3, 2);
    for (int k = 0; k < 11; k++) push_pulse(16, 2);
    build_model(16, 3, 4);
    period_exp = 16; pass_edges = 3;
    play(exp_len, "nominal");
    chk("nominal_code", 32'(err_code), 32'(exp_code));
    chk("nominal_pmeas", 32'(period_meas), 32'(exp_pm));

    // Sixth period stretched to 17 after lock
    clear_train();
    push_pulse(3, 2);
    for (int k = 1; k < 12; k++) push_pulse((k == 6) ? 17 : 16, 2);
    build_model(16, 3, 4);
    play(exp_len, "mismatch");
    chk("mismatch_code", 32'(err_code), 32'd2);
    chk("mismatch_pmeas", 32'(period_meas), 32'd17);

    // SYSREF stops before lock
    clear_train();
    push_pulse(3, 2);
    push_pulse(16, 2);
    push_pulse(16, 2);
    build_model(16, 3, 4);
    play(exp_len, "timeout");
    chk("timeout_code", 32'(err_code), 32'd1);
    chk("timeout_pmeas", 32'(period_meas), 32'd16);

    // Unlimited forwarding, aborted in the middle of a forwarded pulse
    clear_train();
    push_pulse(3, 3);
    for (int k = 0; k < 14; k++) push_pulse(16, 3);
    build_model(16, 0, 4);
    pass_edges = 0;
    cut = s_q[8] + 2;
    play(cut, "pass0");
    abort = 1'b1; sysref_in = wave[cut];
    tick();
    abort = 1'b0;
    chk("abort_flags", 32'({sysref_out, busy, locked, done, err}), 32'd0);
    chk("abort_code", 32'(err_code), 32'd0);
    sysref_in = 1'b0;
    tick();

    // Short period in the measurement phase restarts the lock count
    clear_train();
    push_pulse(3, 2);
    begin
      int g[9] = '{16, 16, 15, 16, 16, 16, 16, 16, 16};
      foreach (g[i]) push_pulse(g[i], 2);
    end
    build_model(16, 1, 4);
    pass_edges = 1;
    play(exp_len, "relock");
    chk("relock_locked_at", 32'(ev[s_q[7]][2]), 32'd1);
    chk("relock_pmeas", 32'(period_meas), 32'd16);

    // Reset while a pulse is being forwarded, then a fresh run
    clear_train();
    push_pulse(3, 4);
    for (int k = 0; k < 10; k++) push_pulse(16, 4);
    build_model(16, 0, 4);
    pass_edges = 0;
    cut = s_q[6] + 2;
    play(cut, "prerst");
    rst = 1'b1; sysref_in = 1'b1;
    tick();
    chk("rst_flags", 32'({sysref_out, busy, locked, done, err}), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_pmeas", 32'(period_meas), 32'd0);
    rst = 1'b0; sysref_in = 1'b0;
    tick();
    clear_train();
    push_pulse(3, 2);
    for (int k = 0; k < 9; k++) push_pulse(16, 2);
    build_model(16, 2, 4);
    pass_edges = 2;
    play(exp_len, "postrst");
    chk("postrst_code", 32'(err_code), 32'(exp_code));

    // Randomised trains with occasional off-by-one periods
    for (int it = 0; it < 6; it++) begin
      expp = $urandom_range(40, 6);
      wmax = (expp - 2 < 5) ? expp - 2 : 5;
      pass = $urandom_range(4, 1);
      clear_train();
      push_pulse($urandom_range(8, 2), $urandom_range(wmax, 1));
      for (int k = 1; k < 20; k++) begin
        per = expp;
        if ($urandom_range(5, 0) == 0) per = ($urandom_range(1, 0) == 1) ? expp + 1 : expp - 1;
        push_pulse(per, $urandom_range(wmax, 1));
      end
      build_model(expp, pass, 4);
      period_exp = CNT_W'(expp);
      pass_edges = 8'(pass);
      play(exp_len, $sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_code", it), 32'(err_code), 32'(exp_code));
      chk($sformatf("rnd%0d_pmeas", it), 32'(period_meas), 32'(exp_pm));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
